// File: rtl/lcd_ctrl.sv
// lcd_ctrl: pulls column bytes from the frame buffer and refreshes a 128x64 dual-controller LCD.
// Build option LCD_MIRROR_EN: data writes select both halves so the image is mirrored right.
module lcd_ctrl #(
  parameter int unsigned EN_LOW_CYC  = 8,
  parameter int unsigned EN_HIGH_CYC = 8,
  parameter int unsigned RST_CYC     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       en,
  output logic       lcd_rst,
  output logic       lcd_cs1,
  output logic       lcd_cs2,
  output logic       lcd_rw,
  output logic       lcd_di,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  localparam int unsigned TX_CYC  = EN_LOW_CYC + EN_HIGH_CYC;
  localparam int unsigned CNT_MAX = (RST_CYC > TX_CYC) ? RST_CYC : TX_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef LCD_MIRROR_EN
  localparam logic DATA_CS2 = 1'b1;
`else
  localparam logic DATA_CS2 = 1'b0;
`endif

  localparam logic [7:0] CMD_ON    = 8'h3F;
  localparam logic [7:0] CMD_LINE0 = 8'hC0;
  localparam logic [7:0] CMD_PAGE  = 8'hB8;
  localparam logic [7:0] CMD_COL0  = 8'h40;

  typedef enum logic [2:0] {
    RST_HOLD,
    INIT_ON,
    INIT_LINE,
    SET_PAGE,
    SET_COL,
    REQ,
    WAIT,
    WR_DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       page;
  logic [5:0]       col;

  logic             in_tx;
  logic             tx_last;
  logic             rst_done;
  logic             cmd_go;
  logic             dat_go;
  logic [7:0]       cmd_byte;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       page_inc;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign page_inc = page + 3'd1;
  assign lcd_rw   = 1'b0;

  // Decode which bus transaction, if any, is launched at the coming edge.
  always_comb begin
    in_tx    = 1'b0;
    cmd_go   = 1'b0;
    cmd_byte = CMD_ON;
    case (state)
      INIT_ON, INIT_LINE, SET_PAGE, SET_COL, WR_DATA: in_tx = 1'b1;
      default: in_tx = 1'b0;
    endcase
    rst_done = (state == RST_HOLD) && (cnt == CNT_W'(RST_CYC - 1));
    tx_last  = in_tx && (cnt == CNT_W'(TX_CYC - 1));
    case (state)
      RST_HOLD: begin
        cmd_go   = rst_done;
        cmd_byte = CMD_ON;
      end
      INIT_ON: begin
        cmd_go   = tx_last;
        cmd_byte = CMD_LINE0;
      end
      INIT_LINE: begin
        cmd_go   = tx_last;
        cmd_byte = CMD_PAGE | {5'd0, page};
      end
      SET_PAGE: begin
        cmd_go   = tx_last;
        cmd_byte = CMD_COL0;
      end
      WR_DATA: begin
        cmd_go   = tx_last && (col == 6'd63);
        cmd_byte = CMD_PAGE | {5'd0, page_inc};
      end
      default: begin
        cmd_go   = 1'b0;
        cmd_byte = CMD_ON;
      end
    endcase
    dat_go = (state == WAIT) && data_valid;
  end

  // Sequencer, bus timing and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_HOLD;
      cnt        <= '0;
      page       <= '0;
      col        <= '0;
      en         <= 1'b0;
      lcd_rst    <= 1'b0;
      lcd_cs1    <= 1'b0;
      lcd_cs2    <= 1'b0;
      lcd_di     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      en         <= 1'b0;
      frame_done <= 1'b0;
      if (in_tx || state == RST_HOLD) begin
        cnt <= cnt_inc;
      end
      if (in_tx) begin
        lcd_en <= (cnt_inc >= CNT_W'(EN_LOW_CYC));
      end

      case (state)
        RST_HOLD: begin
          if (rst_done) begin
            lcd_rst <= 1'b1;
            state   <= INIT_ON;
          end
        end
        INIT_ON:   if (tx_last) state <= INIT_LINE;
        INIT_LINE: if (tx_last) state <= SET_PAGE;
        SET_PAGE:  if (tx_last) state <= SET_COL;
        SET_COL: begin
          if (tx_last) begin
            state <= REQ;
            en    <= 1'b1;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          // No byte yet: re-request until upstream has one.
          if (data_valid) begin
            state <= WR_DATA;
          end else begin
            state <= REQ;
            en    <= 1'b1;
          end
        end
        WR_DATA: begin
          if (tx_last) begin
            col <= col + 6'd1;
            if (col == 6'd63) begin
              page  <= page_inc;
              state <= SET_PAGE;
              if (page == 3'd7) frame_done <= 1'b1;
            end else begin
              state <= REQ;
              en    <= 1'b1;
            end
          end
        end
        default: state <= RST_HOLD;
      endcase

      if (tx_last) begin
        lcd_en <= 1'b0;
        cnt    <= '0;
      end

      // Fields load together at transaction start and hold until the next load.
      if (cmd_go || dat_go) begin
        cnt      <= '0;
        lcd_en   <= 1'b0;
        lcd_di   <= dat_go;
        lcd_cs1  <= 1'b1;
        lcd_cs2  <= dat_go ? DATA_CS2 : 1'b1;
        lcd_data <= dat_go ? data : cmd_byte;
      end
    end
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Downstream consumer of the frame-buffer RAM controller: requests column bytes one at a time over the `en`/`data_valid` handshake and writes them to a 128x64 dual-controller graphic LCD (two 64x64 halves, 8 pages of 8 pixel rows). On reset it runs the LCD power-up and init sequence, then refreshes the left half continuously, page by page and column by column. All LCD bus timing (enable strobe width, setup) is generated from the system clock with cycle counters.

## Interface
- `EN_LOW_CYC`, 8: cycles `lcd_en` stays low per bus transaction (setup phase), ≥1.
- `EN_HIGH_CYC`, 8: cycles `lcd_en` stays high per bus transaction, ≥1.
- `RST_CYC`, 64: cycles `lcd_rst` is held low after reset release, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `data` in 8: column byte from upstream, bit 0 = top row of page.
- `data_valid` in 1: `data` valid this cycle.
- `en` out 1: one-cycle byte request to upstream.
- `lcd_rst` out 1: LCD reset, active-low.
- `lcd_cs1` out 1: left-half chip select.
- `lcd_cs2` out 1: right-half chip select.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_di` out 1: 0 = command, 1 = display data.
- `lcd_en` out 1: LCD enable strobe; LCD latches on its falling edge.
- `lcd_data` out 8: LCD data bus.
- `frame_done` out 1: one-cycle pulse after the last byte of a frame.

## Operation
- States: RST_HOLD, INIT_ON, INIT_LINE, SET_PAGE, SET_COL, REQ, WAIT, WR_DATA.
- RST_HOLD: `lcd_rst`=0 for `RST_CYC` cycles, then 1; go to INIT_ON.
- INIT_ON: command 0x3F (display on), cs1=cs2=1. INIT_LINE: command 0xC0 (start line 0), cs1=cs2=1. Then SET_PAGE with page=0.
- SET_PAGE: command 0xB8|page (page 3 bits). SET_COL: command 0x40 (column 0). For page/column commands cs1=cs2=1.
- REQ: assert `en` for exactly one cycle; go to WAIT.
- WAIT: lasts exactly one cycle, the cycle after the `en` pulse. If `data_valid`=1, capture `data` and go to WR_DATA. Otherwise return to REQ and re-pulse, which covers upstream refilling its buffer. Retries are unbounded.
- WR_DATA: one data transaction (di=1) with the captured byte.
  - col (6 bits) increments. On col wrap 63→0, page increments and the FSM goes to SET_PAGE; otherwise it goes to REQ.
  - After page 7, col 63: pulse `frame_done`, page wraps to 0, go to SET_PAGE. Init is not repeated.
- `data_valid` outside WAIT is ignored; no byte is consumed.
- Bus transaction: all bus fields are loaded at the start of the transaction (di, cs, data), then `lcd_en` is low for `EN_LOW_CYC` cycles and high for `EN_HIGH_CYC` cycles. Fields hold until the next transaction loads. A transaction is never aborted except by reset.
- Reset mid-transaction: every output returns to its reset value immediately; the sequence restarts at RST_HOLD.

## Timing
- Reset values: `lcd_rst`=0, `lcd_cs1`=0, `lcd_cs2`=0, `lcd_rw`=0, `lcd_di`=0, `lcd_en`=0, `lcd_data`=0x00, `en`=0, `frame_done`=0.
- All outputs are registered. `lcd_en` high spans exactly `EN_HIGH_CYC` clocks.
- Transaction length T = `EN_LOW_CYC`+`EN_HIGH_CYC`. The next transaction or REQ starts the cycle after the falling edge of `lcd_en`.
- Byte latency, with upstream always ready: `en` pulse → `data_valid` at +1 → transaction begins at +2.
- Frame = 2 init transactions (first frame only) + 8×(2 command + 64 data) transactions.
- `frame_done` is asserted the cycle after the falling edge of `lcd_en` of the final byte.

## Configuration
- `LCD_MIRROR_EN` defined: data transactions assert cs1=cs2=1, so the same image appears on both halves.
- `LCD_MIRROR_EN` undefined: data transactions assert cs1=1, cs2=0; the right half keeps its power-up contents. Commands always use cs1=cs2=1.

## Test plan
- Reset release, EN_LOW_CYC=EN_HIGH_CYC=2, RST_CYC=4 → `lcd_rst` low 4 cycles. Next transactions: 0x3F, then 0xC0, then 0xB8, then 0x40, each with di=0, `lcd_en` high 2 cycles.
- Upstream model returns `data_valid` one cycle after every `en` with bytes 0x00..0x3F → 64 data transactions on page 0 carry 0x00..0x3F in order; then command 0xB9.
- Upstream withholds `data_valid` for the first 3 requests → `en` re-pulses every 2 cycles (REQ/WAIT); the byte from the 4th request is written once.
- Full frame with an always-ready upstream → `frame_done` is a single pulse after 8×66 transactions. The next command is 0xB8, and no 0x3F is resent.
- `rst_n` dropped while `lcd_en`=1 mid data byte → `lcd_en`=0 and `lcd_data`=0x00 asynchronously; after release, the sequence restarts with a `lcd_rst` low pulse.
- With `LCD_MIRROR_EN` → cs2=1 on data transactions. Without it → cs2=0 on data transactions and cs2=1 on commands.
